// File: rtl/fetch_seq_ctrl_pkg.sv
// Front-end shared types and constants.
// Used by the fetch sequencer and its neighbours.
package fetch_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FLUSH
    } fetch_state_t;

    localparam int FETCH_BYTES_DEFAULT = 8;
    localparam int FETCH_PKT_W = 64;

endpackage

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one I-cache request at a
// time, buffers the packet for decode and drops responses made stale by a redirect.
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int FETCH_BYTES = FETCH_BYTES_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   mispredict,
    input  logic [XLEN-1:0]        actual_target_address,
    input  logic                   pred_redirect,
    input  logic [XLEN-1:0]        pred_target,
    output logic                   ic_req_valid,
    input  logic                   ic_req_ready,
    output logic [XLEN-1:0]        ic_req_addr,
    input  logic                   ic_resp_valid,
    input  logic [FETCH_PKT_W-1:0] ic_resp_data,
    output logic                   fetch_valid,
    output logic [XLEN-1:0]        fetch_pc,
    output logic [FETCH_PKT_W-1:0] fetch_data,
    input  logic                   dec_ready
);

    localparam logic [XLEN-1:0] STEP = XLEN'(FETCH_BYTES);

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    fetch_state_t           state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [XLEN-1:0]        buf_pc_q;
    logic [FETCH_PKT_W-1:0] buf_data_q;
    logic                   cap;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            buf_pc_q   <= '0;
            buf_data_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (cap) begin
                buf_pc_q   <= pc_q;
                buf_data_q <= ic_resp_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (ic_req_ready)
                    state_d = mispredict ? FLUSH : WAIT;
            end
            WAIT: begin
                if (ic_resp_valid) begin
                    state_d = mispredict ? REQ : HOLD;
                    cap     = !mispredict;
                end else if (mispredict) begin
                    state_d = FLUSH;
                end
            end
            HOLD: begin
                if (mispredict) begin
                    state_d = REQ;
                end else if (dec_ready) begin
                    state_d = REQ;
                    pc_d    = pred_redirect ? align4(pred_target)
                                            : buf_pc_q + STEP;
                end
            end
            FLUSH: begin
                if (ic_resp_valid)
                    state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
        // Backend redirect wins over everything, in every state.
        if (mispredict)
            pc_d = align4(actual_target_address);
    end

    assign ic_req_valid = (state_q == REQ);
    assign ic_req_addr  = pc_q;
    assign fetch_valid  = (state_q == HOLD);
    assign fetch_pc     = buf_pc_q;
    assign fetch_data   = buf_data_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Scoreboard bench for fetch_seq_ctrl with a 1-cycle I-cache model.
// Stimulus pushes expected requests/packets; a monitor pops and compares.
module tb_fetch_seq_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] data;
    } pkt_t;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        mispredict = 1'b0;
    logic [31:0] actual_target_address = '0;
    logic        pred_redirect = 1'b0;
    logic [31:0] pred_target = '0;
    logic        ic_req_valid;
    logic        ic_req_ready = 1'b1;
    logic [31:0] ic_req_addr;
    logic        ic_resp_valid = 1'b0;
    logic [63:0] ic_resp_data = '0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [63:0] fetch_data;
    logic        dec_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_req[$];
    pkt_t        exp_pkt[$];

    fetch_seq_ctrl dut (
        .CLK                   (CLK),
        .reset_n               (reset_n),
        .mispredict            (mispredict),
        .actual_target_address (actual_target_address),
        .pred_redirect         (pred_redirect),
        .pred_target           (pred_target),
        .ic_req_valid          (ic_req_valid),
        .ic_req_ready          (ic_req_ready),
        .ic_req_addr           (ic_req_addr),
        .ic_resp_valid         (ic_resp_valid),
        .ic_resp_data          (ic_resp_data),
        .fetch_valid           (fetch_valid),
        .fetch_pc              (fetch_pc),
        .fetch_data            (fetch_data),
        .dec_ready             (dec_ready)
    );

    always #5 CLK = ~CLK;

    function automatic pkt_t mk(input logic [31:0] a);
        pkt_t p;
        p.pc   = a;
        p.data = {~a, a};
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout got none expected event", name);
    endtask

    task automatic wait_hold(input logic [31:0] a);
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (fetch_valid && fetch_pc == a) return;
        end
        timeout("wait_hold");
    endtask

    task automatic wait_req(input logic [31:0] a);
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (ic_req_valid && ic_req_addr == a) return;
        end
        timeout("wait_req");
    endtask

    task automatic pulse_mp(input logic [31:0] t);
        mispredict = 1'b1;
        actual_target_address = t;
        @(posedge CLK);
        #1;
        mispredict = 1'b0;
    endtask

    // I-cache model: answers one cycle after accepting a request.
    initial begin
        logic        pend;
        logic [31:0] paddr;
        forever begin
            @(negedge CLK);
            pend  = reset_n && ic_req_valid && ic_req_ready;
            paddr = ic_req_addr;
            @(posedge CLK);
            #1;
            ic_resp_valid = pend;
            ic_resp_data  = pend ? {~paddr, paddr} : 64'h0;
        end
    end

    // Monitor
    initial begin
        logic        p_mp = 1'b0;
        logic        p_dec = 1'b0;
        logic        p_fv = 1'b0;
        logic        p_resp = 1'b0;
        logic [31:0] p_tgt = '0;
        logic [31:0] ea;
        pkt_t        ep;
        forever begin
            @(negedge CLK);
            if (!reset_n) begin
                p_mp = 1'b0; p_dec = 1'b0; p_fv = 1'b0; p_resp = 1'b0;
                continue;
            end
            if (p_mp) begin
                chk("mp_addr", ic_req_addr, p_tgt);
                chk("mp_fv_drop", fetch_valid, 0);
            end
            if (p_dec)
                chk("dec_to_req", ic_req_valid, 1);
            if (fetch_valid && !p_fv)
                chk("resp_to_fv", p_resp, 1);
            if (ic_resp_valid)
                chk("resp_state", ic_req_valid | fetch_valid, 0);
            if (ic_req_valid && ic_req_ready) begin
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", ic_req_addr, 64'hDEAD);
                end else begin
                    ea = exp_req.pop_front();
                    chk("req_addr", ic_req_addr, ea);
                end
            end
            if (fetch_valid && dec_ready && !mispredict) begin
                if (exp_pkt.size() == 0) begin
                    chk("pkt_unexpected", fetch_pc, 64'hDEAD);
                end else begin
                    ep = exp_pkt.pop_front();
                    chk("pkt_pc", fetch_pc, ep.pc);
                    chk("pkt_data", fetch_data, ep.data);
                end
            end
            p_mp   = mispredict;
            p_tgt  = {actual_target_address[31:2], 2'b00};
            p_dec  = fetch_valid && dec_ready && !mispredict;
            p_fv   = fetch_valid;
            p_resp = ic_resp_valid;
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req_valid", ic_req_valid, 0);
        chk("rst_req_addr", ic_req_addr, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_fetch_pc", fetch_pc, 0);
        chk("rst_fetch_data", fetch_data, 0);

        // Sequential flow, then mispredict on accept of 0x10
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h8);
        exp_req.push_back(32'h10);
        exp_pkt.push_back(mk(32'h0));
        exp_pkt.push_back(mk(32'h8));
        dec_ready = 1'b1;
        reset_n = 1'b1;
        wait_req(32'h10);
        dec_ready = 1'b0;
        exp_req.push_back(32'h2000);
        pulse_mp(32'h2000);

        // Mispredict in HOLD beats dec_ready and pred_redirect
        wait_hold(32'h2000);
        exp_req.push_back(32'h3000);
        dec_ready = 1'b1;
        pred_redirect = 1'b1;
        pred_target = 32'h5000;
        pulse_mp(32'h3000);
        dec_ready = 1'b0;
        pred_redirect = 1'b0;

        // Predicted-taken with misaligned target
        wait_hold(32'h3000);
        exp_req.push_back(32'h100);
        pulse_mp(32'h100);
        wait_hold(32'h100);
        exp_pkt.push_back(mk(32'h100));
        exp_req.push_back(32'h400);
        dec_ready = 1'b1;
        pred_redirect = 1'b1;
        pred_target = 32'h403;
        @(posedge CLK);
        #1;
        dec_ready = 1'b0;
        pred_redirect = 1'b0;

        // Wrap-around at the top of the address space
        wait_hold(32'h400);
        exp_req.push_back(32'hFFFF_FFF8);
        pulse_mp(32'hFFFF_FFFB);
        wait_hold(32'hFFFF_FFF8);
        exp_pkt.push_back(mk(32'hFFFF_FFF8));
        exp_req.push_back(32'h0);
        dec_ready = 1'b1;
        @(posedge CLK);
        #1;
        dec_ready = 1'b0;

        // Reset asserted while in WAIT
        wait_hold(32'h0);
        exp_pkt.push_back(mk(32'h0));
        exp_req.push_back(32'h8);
        dec_ready = 1'b1;
        @(posedge CLK);
        #1;
        dec_ready = 1'b0;
        @(posedge CLK);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req_valid", ic_req_valid, 0);
        chk("arst_req_addr", ic_req_addr, 0);
        chk("arst_fetch_valid", fetch_valid, 0);
        chk("arst_fetch_pc", fetch_pc, 0);
        chk("arst_fetch_data", fetch_data, 0);
        @(posedge CLK);
        #1;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h8);
        exp_pkt.push_back(mk(32'h0));
        dec_ready = 1'b1;
        reset_n = 1'b1;
        wait_req(32'h8);
        dec_ready = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("req_q_empty", 64'(exp_req.size()), 0);
        chk("pkt_q_empty", 64'(exp_pkt.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_seq_ctrl.md
# fetch_seq_ctrl

Fetch sequencer sitting between the PC/next-PC logic, the instruction cache and decode. It owns the architectural fetch PC and sequences one outstanding I-cache request at a time. It applies redirects in priority order (backend mispredict, then front-end predicted-taken), buffers the returned 64-bit fetch packet until decode accepts it, and discards responses made stale by a mispredict.

## Interface
Parameters:
- XLEN, 32, address width
- FETCH_BYTES, 8, bytes per fetch packet (two 32-bit instructions)
- RESET_PC, 0, fetch address after reset

Ports:
- CLK  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mispredict  in  1  backend redirect request, single-cycle pulse
- actual_target_address  in  XLEN  redirect target, valid with mispredict
- pred_redirect  in  1  predictor says the packet on fetch_pc is taken; qualified by fetch_valid
- pred_target  in  XLEN  predicted target, valid with pred_redirect
- ic_req_valid  out  1  I-cache request valid
- ic_req_ready  in  1  I-cache accepts request
- ic_req_addr  out  XLEN  request address, equal to current fetch PC
- ic_resp_valid  in  1  I-cache response valid, single cycle, no backpressure
- ic_resp_data  in  64  fetched packet
- fetch_valid  out  1  packet valid to decode
- fetch_pc  out  XLEN  PC of the buffered packet
- fetch_data  out  64  buffered packet
- dec_ready  in  1  decode accepts packet

## Operation
- States: IDLE, REQ, WAIT, HOLD, FLUSH.
- IDLE: entered only by reset. Goes to REQ on the first clock edge with reset_n high.
- REQ: ic_req_valid=1. On ic_req_ready, go to WAIT.
- WAIT: on ic_resp_valid, capture the data and the current PC into the buffer, then go to HOLD.
- HOLD: fetch_valid=1. On dec_ready, set pc to pred_target if pred_redirect, otherwise to fetch_pc+FETCH_BYTES. Then go to REQ.
- FLUSH: a stale request is outstanding. On ic_resp_valid, drop the data and go to REQ.
- Mispredict has highest priority in every state and always loads pc with actual_target_address. The next state depends on the current state:
  - IDLE, or REQ without ready: go to REQ. The request was not accepted, so its address may change.
  - REQ with ic_req_ready in the same cycle: go to FLUSH.
  - WAIT without resp: go to FLUSH.
  - WAIT with ic_resp_valid in the same cycle: drop the response and go to REQ.
  - HOLD: drop the buffer, ignore dec_ready and pred_redirect, and go to REQ.
  - FLUSH: stay in FLUSH, or go to REQ if ic_resp_valid arrives the same cycle.
- Address arithmetic: all PC values are modulo 2^XLEN, so 0xFFFFFFF8+8 wraps to 0x0. Bits [1:0] of every loaded target are forced to 0.
- Responses arriving in IDLE, REQ or HOLD are protocol errors and are ignored. The bench asserts they never occur.

## Timing
- Reset values:
  - pc=RESET_PC, state IDLE.
  - ic_req_valid=0, ic_req_addr=RESET_PC.
  - fetch_valid=0, fetch_pc=0, fetch_data=0.
- All outputs are registered or decoded from state/pc only. There is no combinational path from any input to any output.
- Request handshake: ic_req_addr is stable while ic_req_valid=1 and not accepted. The only exception is mispredict, which takes effect the next cycle.
- Latency:
  - Response in cycle N gives fetch_valid=1 in N+1.
  - Decode handshake in cycle M gives ic_req_valid=1 in M+1 with the new address.
  - Mispredict in cycle K gives ic_req_addr=target in K+1 (REQ path).
- Peak throughput is one packet per 3 cycles with a 1-cycle I-cache and dec_ready held high.
- Reset asserted mid-operation clears everything immediately. The I-cache shares reset_n, so no stale response survives reset.

## Structure
- Shared front-end package holds:
  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD, FLUSH)
  - FETCH_BYTES_DEFAULT
  - FETCH_PKT_W=64
- Single module. The next-PC select is a few lines and does not warrant a sub-module.
- The packet buffer is a plain register set inside the module.

## Test plan
- Reset then dec_ready=1, 1-cycle cache -> requests at 0x0, 0x8, 0x10; each fetch_valid 1 cycle after its response; next request 1 cycle after decode accept.
- HOLD at fetch_pc=0x100 with pred_redirect=1, pred_target=0x403, dec_ready=1 -> next ic_req_addr=0x400.
- Mispredict to 0x2000 in the same cycle as ic_req_ready for 0x10 -> FLUSH; response for 0x10 produces no fetch_valid; next request is 0x2000.
- Mispredict to 0x3000 while in HOLD with dec_ready=1 and pred_redirect=1 -> packet not consumed; fetch_valid drops next cycle; request 0x3000.
- pc=0xFFFFFFF8, no redirect, accept -> next ic_req_addr=0x00000000.
- reset_n pulsed low while in WAIT -> outputs return to reset values asynchronously; fetch restarts at RESET_PC.
